// File: rtl/axi_lite_mem_slave_if.sv
// rtl/axi_lite_mem_slave_if.sv - AXI4-Lite bus bundle between the fill/write-back master and the memory responder
interface axi_lite_mem_slave_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI4-Lite word-array memory responder with configurable read latency
module axi_lite_mem_slave #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 2
) (
   input logic                 clk_i,
   input logic                 arst_ni,
   axi_lite_mem_slave_if.slave bus
);
   localparam int IW = $clog2(MEM_DEPTH);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Address decode: word index from addr[IW+1:2], anything above the array is out of range
   logic [IW-1:0] aw_idx;
   logic          aw_ok;
   logic [IW-1:0] ar_idx;
   logic          ar_ok;
   logic          unused_addr_bits;

   assign aw_idx           = bus.awaddr[IW+1:2];
   assign aw_ok            = (bus.awaddr[ADDR_WIDTH-1:IW+2] == '0);
   assign ar_idx           = bus.araddr[IW+1:2];
   assign ar_ok            = (bus.araddr[ADDR_WIDTH-1:IW+2] == '0);
   assign unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0]};

   // ------------------------------------------------------------------ write
   w_state_e              w_state_q;
   w_state_e              w_state_d;
   logic                  aw_cap_q;
   logic                  w_cap_q;
   logic [IW-1:0]         aw_idx_q;
   logic                  aw_ok_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [SW-1:0]         wstrb_q;
   logic [1:0]            bresp_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  w_commit;
   logic [IW-1:0]         cm_idx;
   logic                  cm_ok;
   logic [DATA_WIDTH-1:0] cm_data;
   logic [SW-1:0]         cm_strb;

   // A beat already captured takes precedence over the live bus for that channel
   assign aw_hs    = bus.awvalid & bus.awready;
   assign w_hs     = bus.wvalid & bus.wready;
   assign w_commit = (w_state_q == W_IDLE) & (aw_cap_q | aw_hs) & (w_cap_q | w_hs);
   assign cm_idx   = aw_cap_q ? aw_idx_q : aw_idx;
   assign cm_ok    = aw_cap_q ? aw_ok_q  : aw_ok;
   assign cm_data  = w_cap_q  ? wdata_q  : bus.wdata;
   assign cm_strb  = w_cap_q  ? wstrb_q  : bus.wstrb;
   assign bus.bresp = bresp_q;

   // Write FSM state register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) w_state_q <= W_IDLE;
      else          w_state_q <= w_state_d;
   end

   // Write FSM next state: commit once both beats are in, leave on the B handshake
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (w_commit)   w_state_d = W_RESP;
         W_RESP:  if (bus.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write FSM outputs: readies come only from registered state, never from bready
   always_comb begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            bus.awready = ~aw_cap_q;
            bus.wready  = ~w_cap_q;
         end
         W_RESP:  bus.bvalid = 1'b1;
         default: ;
      endcase
   end

   // Capture AW and W independently; flags clear after the response is taken
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         aw_cap_q <= 1'b0;
         w_cap_q  <= 1'b0;
         aw_idx_q <= '0;
         aw_ok_q  <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (w_state_q == W_RESP && bus.bready) begin
            aw_cap_q <= 1'b0;
            w_cap_q  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_cap_q <= 1'b1;
               aw_idx_q <= aw_idx;
               aw_ok_q  <= aw_ok;
            end
            if (w_hs) begin
               w_cap_q <= 1'b1;
               wdata_q <= bus.wdata;
               wstrb_q <= bus.wstrb;
            end
         end
         if (w_commit) bresp_q <= cm_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Byte-lane array write on the commit edge; out-of-range writes are dropped
   always_ff @(posedge clk_i) begin
      if (w_commit && cm_ok) begin
         for (int b = 0; b < SW; b++) begin
            if (cm_strb[b]) mem[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------ read
   r_state_e              r_state_q;
   r_state_e              r_state_d;
   logic [CW-1:0]         cnt_q;
   logic [IW-1:0]         ar_idx_q;
   logic                  ar_ok_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic                  ar_hs;
   logic                  r_sample;
   logic [IW-1:0]         smp_idx;
   logic                  smp_ok;

   // With a latency of one the sample happens on the AR edge, so use the live address then
   assign ar_hs     = bus.arvalid & bus.arready;
   assign r_sample  = (r_state_d == R_RESP) & (r_state_q != R_RESP);
   assign smp_idx   = (r_state_q == R_IDLE) ? ar_idx : ar_idx_q;
   assign smp_ok    = (r_state_q == R_IDLE) ? ar_ok  : ar_ok_q;
   assign bus.rdata = rdata_q;
   assign bus.rresp = rresp_q;

   // Read FSM state register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) r_state_q <= R_IDLE;
      else          r_state_q <= r_state_d;
   end

   // Read FSM next state: wait out the latency counter, then hold until rready
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = (READ_LATENCY == 1) ? R_RESP : R_WAIT;
         R_WAIT:  if (cnt_q == CW'(1)) r_state_d = R_RESP;
         R_RESP:  if (bus.rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      case (r_state_q)
         R_IDLE:  bus.arready = 1'b1;
         R_RESP:  bus.rvalid  = 1'b1;
         default: ;
      endcase
   end

   // Latch the read address, run the latency counter and sample the array on entry to R_RESP
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q    <= '0;
         ar_idx_q <= '0;
         ar_ok_q  <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         if (r_state_q == R_IDLE && ar_hs) begin
            ar_idx_q <= ar_idx;
            ar_ok_q  <= ar_ok;
            cnt_q    <= CW'(READ_LATENCY - 1);
         end else if (r_state_q == R_WAIT) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (r_sample) begin
            rdata_q <= smp_ok ? mem[smp_idx] : '0;
            rresp_q <= smp_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end
endmodule
